sub_bytes: RTL and testbench

//  - AES SubBytes stage: replaces each of the 16 bytes of a 128-bit AES state with
//    its FIPS-197 S-box value.
//  - Sits in the AES round datapath between AddRoundKey and ShiftRows.
//  - Output is registered: one pipeline stage per round pass.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 11 +
 rtl/sub_bytes.sv | 28 ++
 tb/tb_sub_bytes.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths and the forward S-box table.
// The table lives here so the key-expansion SubWord can reuse the same constant.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_NUM_BYTES = AES_STATE_W / AES_BYTE_W;

  // FIPS-197 forward S-box, indexed by input byte value
  localparam logic [AES_BYTE_W-1:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [AES_BYTE_W-1:0] sbox(input logic [AES_BYTE_W-1:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box for one byte lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] data,
  output logic [AES_BYTE_W-1:0] sbox_c
);

  assign sbox_c = sbox(data);

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes stage: 16 independent S-box lanes feeding one 128-bit output register.
module sub_bytes
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic [AES_STATE_W-1:0] state_out
);

  logic [AES_STATE_W-1:0] sub_c;

  for (genvar k = 0; k < AES_NUM_BYTES; k++) begin : g_lane
    aes_sbox u_sbox (
      .data   (state_in[k*AES_BYTE_W +: AES_BYTE_W]),
      .sbox_c (sub_c[k*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out <= '0;
    end else begin
      state_out <= sub_c;
    end
  end

endmodule

// File: tb/tb_sub_bytes.sv
// Bench for sub_bytes: fixed vectors, exhaustive lane sweep, random streaming, reset cases.
module tb_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic [127:0] state_in;
  logic [127:0] state_out;

  int checks;
  int failures;

  logic [7:0] ref_sbox [256];

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_in  (state_in),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // inverse by search, then affine transform
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (a != 8'h00 && gf_mul(a, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply(input string name, input logic [127:0] din, input logic [127:0] exp);
    @(negedge clk);
    state_in = din;
    @(posedge clk);
    #1;
    check(name, state_out, exp);
  endtask

  initial begin
    logic [127:0] a, b, prev;
    checks   = 0;
    failures = 0;
    for (int v = 0; v < 256; v++) ref_sbox[v] = sbox_calc(8'(v));

    vecs[0] = '{"fips_round1", 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
    vecs[1] = '{"all_00",      128'h0,                                   {16{8'h63}}};
    vecs[2] = '{"all_ff",      {16{8'hff}},                              {16{8'h16}}};
    vecs[3] = '{"sweep_00_0f", 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h637c777b_f26b6fc5_3001672b_fed7ab76};
    vecs[4] = '{"anchor_53",   {16{8'h53}},                              {16{8'hed}}};

    // reset asserted with random input, before any clock edge
    rst_n    = 1'b0;
    state_in = rand128();
    #2;
    check("reset_immediate", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_hold", state_out, 128'h0);
    a = state_in;
    @(posedge clk);
    #1;
    check("reset_first_edge", state_out, sub_ref(a));

    for (int i = 0; i < 5; i++) apply(vecs[i].name, vecs[i].din, vecs[i].exp);

    // back-to-back streaming with exact 1-cycle latency
    apply("stream_a", 128'ha49c7ff2_689f352b_6b5bea43_026a5049, 128'h49ded289_45db96f1_7f39871a_7702533b);
    @(negedge clk);
    state_in = 128'haa8f5f03_61dde3ef_82d24ad2_6832469a;
    #1;
    check("stream_hold", state_out, 128'h49ded289_45db96f1_7f39871a_7702533b);
    @(posedge clk);
    #1;
    check("stream_b", state_out, 128'hac73cf7b_efc111df_13b5d6b5_45235ab8);

    // every value in every lane against the model
    for (int v = 0; v < 256; v++) apply($sformatf("lane_%02h", v), {16{8'(v)}}, {16{ref_sbox[v]}});

    // random streaming
    for (int i = 0; i < 200; i++) begin
      a = rand128();
      apply($sformatf("rand_%0d", i), a, sub_ref(a));
    end

    // async reset between edges while streaming, then resume
    a = rand128();
    apply("pre_reset", a, sub_ref(a));
    prev = a;
    @(negedge clk);
    state_in = rand128();
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", state_out, 128'h0);
    @(posedge clk);
    #1;
    check("mid_reset_held", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    b = rand128();
    state_in = b;
    #1;
    check("mid_release_hold", state_out, 128'h0);
    @(posedge clk);
    #1;
    check("resume_first", state_out, sub_ref(b));
    if (b == prev) b = ~b;
    for (int i = 0; i < 8; i++) begin
      a = rand128();
      apply($sformatf("resume_%0d", i), a, sub_ref(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
